// File: rtl/io_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : io_responder_if
//  Brief    : CPU port bus plus TX sink / RX source handshakes for io_responder.
//  Revision : 1.0
// ============================================================================
interface io_responder_if;
  logic [15:0] addr;
  logic [15:0] data;
  logic        write;
  logic [15:0] data_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;

  modport master (
    output addr, data, write, tx_ready, rx_valid, rx_data,
    input  data_out, tx_valid, tx_data
  );

  modport slave (
    input  addr, data, write, tx_ready, rx_valid, rx_data,
    output data_out, tx_valid, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : io_responder
//  Brief    : Port-bus peripheral: TX/RX byte FIFOs, status register, timer.
//             Define IO_LOOPBACK_EN to route the TX FIFO head into the RX FIFO.
//  Revision : 1.0
// ============================================================================
module io_responder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  io_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] A_TX   = BASE_ADDR;
  localparam logic [15:0] A_RX   = BASE_ADDR + 16'd1;
  localparam logic [15:0] A_STAT = BASE_ADDR + 16'd2;
  localparam logic [15:0] A_TMR  = BASE_ADDR + 16'd3;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   data_out_q, data_out_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic wr_tx, wr_rx, wr_stat, wr_tmr;
  logic tx_push, tx_pop, tx_ovf_evt;
  logic rx_push, rx_pop, rx_ovf_evt;
  logic [7:0]  tx_head, rx_head, rx_in;
  logic [15:0] rd_val;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  // Full: same slot index, opposite wrap bit.
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  assign tx_head = tx_mem_q[tx_rd_q[AW-1:0]];
  assign rx_head = rx_mem_q[rx_rd_q[AW-1:0]];

  assign wr_tx   = bus.write && (bus.addr == A_TX);
  assign wr_rx   = bus.write && (bus.addr == A_RX);
  assign wr_stat = bus.write && (bus.addr == A_STAT);
  assign wr_tmr  = bus.write && (bus.addr == A_TMR);

  assign tx_push    = wr_tx && !tx_full;
  assign tx_ovf_evt = wr_tx && tx_full;
  assign rx_pop     = wr_rx && !rx_empty;

`ifdef IO_LOOPBACK_EN
  assign tx_pop       = !tx_empty && !rx_full;
  assign rx_push      = tx_pop;
  assign rx_in        = tx_head;
  assign rx_ovf_evt   = 1'b0;
  assign bus.tx_valid = 1'b0;
  assign bus.tx_data  = 8'h00;
`else
  assign tx_pop       = !tx_empty && bus.tx_ready;
  assign rx_push      = bus.rx_valid && !rx_full;
  assign rx_in        = bus.rx_data;
  assign rx_ovf_evt   = bus.rx_valid && rx_full;
  assign bus.tx_valid = !tx_empty;
  // Storage is not reset, so an empty FIFO must present a clean zero.
  assign bus.tx_data  = tx_empty ? 8'h00 : tx_head;
`endif

  assign bus.data_out = data_out_q;

  always_comb begin
    rd_val = 16'h0000;
    if (bus.addr == A_RX)
      rd_val = rx_empty ? 16'h0000 : {8'h00, rx_head};
    else if (bus.addr == A_STAT)
      rd_val = {10'b0, rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_empty, tx_full};
    else if (bus.addr == A_TMR)
      rd_val = timer_q;
  end

  always_comb begin
    tx_wr_d    = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
    tx_rd_d    = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;
    rx_wr_d    = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
    rx_rd_d    = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
    // A new overflow in the same cycle as its W1C clear leaves the bit set.
    tx_ovf_d   = (tx_ovf_q && !(wr_stat && bus.data[4])) || tx_ovf_evt;
    rx_ovf_d   = (rx_ovf_q && !(wr_stat && bus.data[5])) || rx_ovf_evt;
    timer_d    = wr_tmr ? bus.data : timer_q + 16'd1;
    data_out_d = bus.write ? data_out_q : rd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      timer_q    <= 16'h0000;
      data_out_q <= 16'h0000;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      timer_q    <= timer_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem_q[tx_wr_q[AW-1:0]] <= bus.data[7:0];
    if (rx_push)
      rx_mem_q[rx_wr_q[AW-1:0]] <= rx_in;
  end

endmodule
`default_nettype wire
